nios_memory_arbiter: RTL

//  Shares the single-port 2048x32 on-chip RAM between two Avalon-MM masters:
//  m0 = Nios data master, m1 = pong video/sprite fetch engine.

---
 rtl/nios_memory_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/nios_memory_arbiter.sv
// rtl/nios_memory_arbiter.sv - two-master Avalon-MM arbiter for the shared single-port 2048x32 RAM
// Define NIOS_MEM_ARB_PRIORITY_EN for fixed m0 priority with m1 anti-starvation; default is round-robin.

module nios_memory_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic m0_req, m1_req;
  logic grant0, grant1;
  logic m1_first;
  logic rd_valid_q, rd_valid_d;
  logic rd_port_q, rd_port_d;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

`ifdef NIOS_MEM_ARB_PRIORITY_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_q, starve_cnt_d;

  // m1 only overrides m0 once it has been denied STARVE_LIMIT cycles in a row.
  assign m1_first = (starve_cnt_q == STARVE_LIM);

  always_comb begin
    starve_cnt_d = starve_cnt_q + 4'd1;
    if (!m1_req || grant1) starve_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end
`else
  logic       last_grant_q, last_grant_d;
  logic [3:0] unused_starve_limit;

  assign unused_starve_limit = 4'(STARVE_LIMIT);
  assign m1_first            = ~last_grant_q;

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant0) last_grant_d = 1'b0;
    if (grant1) last_grant_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end
`endif

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (m0_req && m1_req) begin
        grant1 = m1_first;
        grant0 = ~m1_first;
      end else begin
        grant0 = m0_req;
        grant1 = m1_req;
      end
    end
  end

  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    mem_write      = grant0 & m0_write;
    if (grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end
  end

  assign mem_chipselect = grant0 | grant1;
  assign mem_clken      = ~reset;
  assign m0_waitrequest = reset | (m0_req & ~grant0);
  assign m1_waitrequest = reset | (m1_req & ~grant1);

  // A read+write request is a write, so it never produces a response.
  assign rd_valid_d = (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);
  assign rd_port_d  = grant1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_port_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_port_q  <= rd_port_d;
    end
  end

  assign m0_readdatavalid = ~reset & rd_valid_q & ~rd_port_q;
  assign m1_readdatavalid = ~reset & rd_valid_q & rd_port_q;
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

endmodule
